// File: rtl/phase_sequencer_if.sv
// Bus between the phase sequencer, its four sub-blocks and the shared RAM.
// The master side is the sequencer. The slave side is the sub-block and RAM environment.
interface phase_sequencer_if #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 11
);
   logic [3:0]              ph_en;
   logic [3:0]              ph_start;
   logic [3:0]              ph_done;
   logic [4*ADDR_WIDTH-1:0] ph_address;
   logic [3:0]              ph_wr_en;
   logic [4*WORD_WIDTH-1:0] ph_data_out;
   logic [ADDR_WIDTH-1:0]   mem_address;
   logic                    mem_wr_en;
   logic [WORD_WIDTH-1:0]   mem_data_out;

   modport master (
      output ph_en, ph_start, mem_address, mem_wr_en, mem_data_out,
      input  ph_done, ph_address, ph_wr_en, ph_data_out
   );

   modport slave (
      input  ph_en, ph_start, mem_address, mem_wr_en, mem_data_out,
      output ph_done, ph_address, ph_wr_en, ph_data_out
   );
endinterface

// File: rtl/phase_sequencer.sv
// Runs up to four RAM-sharing sub-blocks in fixed order 0..3. Only the phase in WAIT owns the RAM.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for go; latches phase_mask on acceptance
// S_SELECT | pick lowest enabled phase at or above idx, or finish
// S_ARM    | ph_en pulse to the selected phase
// S_START  | ph_start pulse to the selected phase
// S_WAIT   | phase owns the RAM; wait for its done or for the watchdog
// S_NEXT   | phase complete; advance idx or finish after phase 3
// S_FINISH | run over; done is pulsed and busy drops on leaving
module phase_sequencer #(
   parameter int WORD_WIDTH = 16,
   parameter int ADDR_WIDTH = 11,
   parameter int TIMEOUT    = 4095
) (
   input  logic              clock,
   input  logic              nrst,
   input  logic              go,
   input  logic [3:0]        phase_mask,
   phase_sequencer_if.master bus,
   output logic              busy,
   output logic              done,
   output logic [1:0]        cur_phase,
   output logic [3:0]        phases_done,
   output logic              timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_ARM,
      S_START,
      S_WAIT,
      S_NEXT,
      S_FINISH
   } state_t;

   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

   state_t      state;
   logic [3:0]  mask_q;
   logic [1:0]  idx;
   logic [3:0]  ph_en_q;
   logic [3:0]  ph_start_q;
   logic        owner_valid;
   logic [15:0] wdog;
   logic        sel_found;
   logic [1:0]  sel_phase;

   logic [ADDR_WIDTH-1:0] mem_address_c;
   logic                  mem_wr_en_c;
   logic [WORD_WIDTH-1:0] mem_data_out_c;

   function automatic logic [3:0] phase_bit(input logic [1:0] p);
      phase_bit = 4'b0001 << p;
   endfunction

   // Descending scan so the last hit is the lowest qualifying phase.
   always_comb begin
      sel_found = 1'b0;
      sel_phase = 2'd0;
      for (int p = 3; p >= 0; p--) begin
         if (mask_q[p] && (2'(p) >= idx)) begin
            sel_found = 1'b1;
            sel_phase = 2'(p);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!nrst) begin
         state       <= S_IDLE;
         mask_q      <= 4'd0;
         idx         <= 2'd0;
         cur_phase   <= 2'd0;
         ph_en_q     <= 4'd0;
         ph_start_q  <= 4'd0;
         owner_valid <= 1'b0;
         wdog        <= 16'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         phases_done <= 4'd0;
         timeout_err <= 1'b0;
      end else begin
         ph_en_q    <= 4'd0;
         ph_start_q <= 4'd0;
         done       <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  mask_q      <= phase_mask;
                  idx         <= 2'd0;
                  phases_done <= 4'd0;
                  timeout_err <= 1'b0;
                  busy        <= 1'b1;
                  state       <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (sel_found) begin
                  cur_phase <= sel_phase;
                  ph_en_q   <= phase_bit(sel_phase);
                  state     <= S_ARM;
               end else begin
                  state <= S_FINISH;
               end
            end
            S_ARM: begin
               ph_start_q <= phase_bit(cur_phase);
               state      <= S_START;
            end
            S_START: begin
               owner_valid <= 1'b1;
               wdog        <= 16'd0;
               state       <= S_WAIT;
            end
            S_WAIT: begin
               wdog <= wdog + 16'd1;
               if (bus.ph_done[cur_phase]) begin
                  phases_done[cur_phase] <= 1'b1;
                  owner_valid            <= 1'b0;
                  state                  <= S_NEXT;
               end else if (wdog == WDOG_LAST) begin
                  timeout_err <= 1'b1;
                  owner_valid <= 1'b0;
                  state       <= S_FINISH;
               end
            end
            S_NEXT: begin
               if (cur_phase == 2'd3) begin
                  state <= S_FINISH;
               end else begin
                  idx   <= cur_phase + 2'd1;
                  state <= S_SELECT;
               end
            end
            S_FINISH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // RAM sees the owning phase only; everything else is forced to zero.
   always_comb begin
      mem_address_c  = '0;
      mem_wr_en_c    = 1'b0;
      mem_data_out_c = '0;
      if (owner_valid) begin
         for (int p = 0; p < 4; p++) begin
            if (cur_phase == 2'(p)) begin
               mem_address_c  = bus.ph_address[p*ADDR_WIDTH +: ADDR_WIDTH];
               mem_wr_en_c    = bus.ph_wr_en[p];
               mem_data_out_c = bus.ph_data_out[p*WORD_WIDTH +: WORD_WIDTH];
            end
         end
      end
   end

   assign bus.ph_en        = ph_en_q;
   assign bus.ph_start     = ph_start_q;
   assign bus.mem_address  = mem_address_c;
   assign bus.mem_wr_en    = mem_wr_en_c;
   assign bus.mem_data_out = mem_data_out_c;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: sub-block responders, RAM ownership monitor and per-scenario run checks.
module tb_phase_sequencer;
   localparam int WORD_W     = 16;
   localparam int ADDR_W     = 11;
   localparam int TIMEOUT_TB = 16;

   logic       clock;
   logic       nrst;
   logic       go;
   logic [3:0] phase_mask;
   logic       busy;
   logic       done;
   logic [1:0] cur_phase;
   logic [3:0] phases_done;
   logic       timeout_err;

   phase_sequencer_if #(.WORD_WIDTH(WORD_W), .ADDR_WIDTH(ADDR_W)) bus_if ();

   phase_sequencer #(
      .WORD_WIDTH(WORD_W),
      .ADDR_WIDTH(ADDR_W),
      .TIMEOUT   (TIMEOUT_TB)
   ) dut (
      .clock      (clock),
      .nrst       (nrst),
      .go         (go),
      .phase_mask (phase_mask),
      .bus        (bus_if),
      .busy       (busy),
      .done       (done),
      .cur_phase  (cur_phase),
      .phases_done(phases_done),
      .timeout_err(timeout_err)
   );

   int n_pass = 0;
   int n_total = 0;

   // environment state shared by the monitor and the scenario tasks
   bit              mon_on = 0;
   bit              fixed_bus = 0;
   logic [3:0]      run_mask = 4'd0;
   int              delay [4];
   bit              hang [4];
   int              cnt [4];
   logic [3:0]      done_v = 4'd0;
   logic [ADDR_W-1:0] addr_v [4];
   logic              we_v [4];
   logic [WORD_W-1:0] dat_v [4];
   int              own = -1;
   int              wcnt = 0;
   int              started;
   int              en_q [$];
   int              start_q [$];
   int              done_cnt = 0;
   int              busy_cyc = 0;
   int              good248 = 0;
   int              bad1c8 = 0;
   logic [ADDR_W-1:0] exp_addr;
   logic              exp_we;
   logic [WORD_W-1:0] exp_dat;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL global_timeout simulation did not finish, got t=%0t required earlier end", $time);
      $fatal(1);
   end

   // Mid-cycle monitor: check RAM ownership, record pulses, then drive sub-block responses.
   initial begin
      forever begin
         @(negedge clock);
         if (mon_on) begin
            exp_addr = '0;
            exp_we   = 1'b0;
            exp_dat  = '0;
            if (own >= 0) begin
               exp_addr = addr_v[own];
               exp_we   = we_v[own];
               exp_dat  = dat_v[own];
            end
            n_total++;
            if (bus_if.mem_address !== exp_addr || bus_if.mem_wr_en !== exp_we ||
                bus_if.mem_data_out !== exp_dat)
               $display("FAIL mem_mux t=%0t got addr=%h we=%b data=%h required addr=%h we=%b data=%h",
                        $time, bus_if.mem_address, bus_if.mem_wr_en, bus_if.mem_data_out,
                        exp_addr, exp_we, exp_dat);
            else
               n_pass++;

            n_total++;
            if (!$onehot0(bus_if.ph_en) || !$onehot0(bus_if.ph_start) ||
                (bus_if.ph_en != 4'd0 && bus_if.ph_start != 4'd0))
               $display("FAIL pulse_excl t=%0t got ph_en=%b ph_start=%b required at most one bit, not both",
                        $time, bus_if.ph_en, bus_if.ph_start);
            else
               n_pass++;

            for (int p = 0; p < 4; p++) begin
               if (bus_if.ph_en[p])    en_q.push_back(p);
               if (bus_if.ph_start[p]) start_q.push_back(p);
            end
            if (done) done_cnt++;
            if (busy) busy_cyc++;
            if (bus_if.mem_wr_en && bus_if.mem_address == 11'h248 && bus_if.mem_data_out == 16'h00AB)
               good248++;
            if (bus_if.mem_wr_en && bus_if.mem_address == 11'h1C8)
               bad1c8++;

            // sub-block responders: arm clears done, start begins a countdown to done
            for (int p = 0; p < 4; p++) begin
               if (bus_if.ph_en[p]) begin
                  done_v[p] = 1'b0;
                  cnt[p]    = 0;
               end
               if (bus_if.ph_start[p]) begin
                  cnt[p] = hang[p] ? 0 : delay[p];
               end else if (cnt[p] > 0) begin
                  cnt[p]--;
                  if (cnt[p] == 0) done_v[p] = 1'b1;
               end
               if (!run_mask[p]) done_v[p] = 1'($urandom_range(0, 1));
            end

            if (nrst !== 1'b1) begin
               own = -1;
            end else begin
               started = -1;
               for (int p = 0; p < 4; p++) if (bus_if.ph_start[p]) started = p;
               if (started >= 0) begin
                  own  = started;
                  wcnt = 0;
               end else if (own >= 0) begin
                  wcnt++;
                  if (done_v[own] || wcnt == TIMEOUT_TB) own = -1;
               end
            end

            for (int p = 0; p < 4; p++) begin
               if (fixed_bus) begin
                  addr_v[p] = (p == 0) ? 11'h248 : (p == 2) ? 11'h1C8 : 11'h000;
                  we_v[p]   = (p == 0 || p == 2);
                  dat_v[p]  = (p == 0) ? 16'h00AB : (p == 2) ? 16'h5555 : 16'h0000;
               end else begin
                  addr_v[p] = 11'($urandom);
                  we_v[p]   = 1'($urandom);
                  dat_v[p]  = 16'($urandom);
               end
               bus_if.ph_address[p*ADDR_W +: ADDR_W]  = addr_v[p];
               bus_if.ph_wr_en[p]                     = we_v[p];
               bus_if.ph_data_out[p*WORD_W +: WORD_W] = dat_v[p];
            end
            bus_if.ph_done = done_v;
         end
      end
   end

   // One complete run from go to done; expectations come from the mask, delays and hung phase.
   task automatic run_case(input string name, input logic [3:0] mask, input int hang_ph, input bit go_again);
      int         exp_code, en_code, st_code, exp_cyc, last, c;
      logic [3:0] exp_pd;
      logic       exp_to;
      bit         stopped;
      exp_code = 0; exp_cyc = 0; last = -1; exp_pd = 4'd0; exp_to = 1'b0; stopped = 0;
      for (int p = 0; p < 4; p++) hang[p] = (p == hang_ph);
      for (int p = 0; p < 4; p++) begin
         if (mask[p] && !stopped) begin
            exp_code = exp_code * 5 + p + 1;
            last = p;
            if (p == hang_ph) begin
               exp_cyc += 3 + TIMEOUT_TB;
               exp_to   = 1'b1;
               stopped  = 1;
            end else begin
               exp_cyc  += 4 + delay[p];
               exp_pd[p] = 1'b1;
            end
         end
      end
      if (!exp_to && !mask[3]) exp_cyc += 1;
      exp_cyc += 1;

      @(posedge clock); #1;
      en_q.delete(); start_q.delete(); done_cnt = 0; busy_cyc = 0;
      run_mask = mask; phase_mask = mask; go = 1'b1;
      @(posedge clock); #1;
      go = 1'b0; phase_mask = 4'($urandom);
      if (go_again) begin
         repeat (3) @(posedge clock);
         #1; go = 1'b1; phase_mask = 4'hF;
         @(posedge clock); #1; go = 1'b0;
      end
      c = 0;
      while (done_cnt == 0 && c < 3000) begin
         @(posedge clock);
         c++;
      end
      repeat (4) @(posedge clock);
      #1;

      en_code = 0; st_code = 0;
      foreach (en_q[i])    en_code = en_code * 5 + en_q[i] + 1;
      foreach (start_q[i]) st_code = st_code * 5 + start_q[i] + 1;

      n_total++;
      if (done_cnt !== 1) $display("FAIL %s done_pulses got %0d required 1", name, done_cnt);
      else n_pass++;
      n_total++;
      if (en_code !== exp_code) $display("FAIL %s en_order got code %0d required %0d", name, en_code, exp_code);
      else n_pass++;
      n_total++;
      if (st_code !== exp_code) $display("FAIL %s start_order got code %0d required %0d", name, st_code, exp_code);
      else n_pass++;
      n_total++;
      if (phases_done !== exp_pd) $display("FAIL %s phases_done got %b required %b", name, phases_done, exp_pd);
      else n_pass++;
      n_total++;
      if (timeout_err !== exp_to) $display("FAIL %s timeout_err got %b required %b", name, timeout_err, exp_to);
      else n_pass++;
      n_total++;
      if (busy_cyc !== exp_cyc) $display("FAIL %s busy_cycles got %0d required %0d", name, busy_cyc, exp_cyc);
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL %s busy_after got %b required 0", name, busy);
      else n_pass++;
      if (last >= 0) begin
         n_total++;
         if (cur_phase !== 2'(last)) $display("FAIL %s cur_phase got %0d required %0d", name, cur_phase, last);
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      nrst = 1'b0; go = 1'b1; phase_mask = 4'hF;
      bus_if.ph_done = 4'hF; bus_if.ph_wr_en = 4'hF;
      bus_if.ph_address = '1; bus_if.ph_data_out = '1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_total++;
      if ({bus_if.ph_en, bus_if.ph_start} !== 8'd0)
         $display("FAIL reset_pulses got ph_en=%b ph_start=%b required 0", bus_if.ph_en, bus_if.ph_start);
      else n_pass++;
      n_total++;
      if ({busy, done, cur_phase, phases_done, timeout_err} !== 9'd0)
         $display("FAIL reset_status got busy=%b done=%b cur=%0d pd=%b to=%b required all 0",
                  busy, done, cur_phase, phases_done, timeout_err);
      else n_pass++;
      n_total++;
      if (bus_if.mem_wr_en !== 1'b0 || bus_if.mem_address !== '0 || bus_if.mem_data_out !== '0)
         $display("FAIL reset_mem got we=%b addr=%h data=%h required 0",
                  bus_if.mem_wr_en, bus_if.mem_address, bus_if.mem_data_out);
      else n_pass++;
      @(posedge clock); #1;
      nrst = 1'b1; go = 1'b0; bus_if.ph_done = 4'h0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         n_total++;
         if (bus_if.ph_en !== 4'd0 || busy !== 1'b0)
            $display("FAIL reset_release cycle %0d got ph_en=%b busy=%b required 0", k, bus_if.ph_en, busy);
         else n_pass++;
      end
      @(posedge clock); #1;
      mon_on = 1;
   endtask

   task automatic test_mask_1011;
      for (int p = 0; p < 4; p++) delay[p] = 5;
      run_case("mask_1011", 4'b1011, -1, 0);
   endtask

   task automatic test_empty_mask;
      run_case("mask_0000", 4'b0000, -1, 0);
   endtask

   task automatic test_timeout;
      for (int p = 0; p < 4; p++) delay[p] = 5;
      run_case("timeout_ph1", 4'b1111, 1, 0);
   endtask

   task automatic test_mem_isolation;
      delay[0] = 6;
      @(posedge clock); #1;
      fixed_bus = 1; good248 = 0; bad1c8 = 0;
      run_case("mem_iso", 4'b0001, -1, 0);
      n_total++;
      if (good248 !== delay[0]) $display("FAIL mem_owner_writes got %0d required %0d", good248, delay[0]);
      else n_pass++;
      n_total++;
      if (bad1c8 !== 0) $display("FAIL mem_foreign_writes got %0d required 0", bad1c8);
      else n_pass++;
      fixed_bus = 0;
   endtask

   task automatic test_back_to_back;
      delay[0] = 3;
      run_case("stale_first", 4'b0001, -1, 0);
      run_case("stale_second", 4'b0001, -1, 1);
   endtask

   task automatic test_random;
      logic [3:0] m;
      int         h;
      for (int it = 0; it < 8; it++) begin
         m = 4'($urandom);
         for (int p = 0; p < 4; p++) delay[p] = $urandom_range(1, 8);
         h = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1;
         run_case($sformatf("rand%0d", it), m, h, (m != 4'd0) && ($urandom_range(0, 1) == 1));
      end
   endtask

   task automatic test_reset_mid_wait;
      int c;
      for (int p = 0; p < 4; p++) hang[p] = (p == 0);
      @(posedge clock); #1;
      en_q.delete(); start_q.delete(); done_cnt = 0;
      run_mask = 4'b0001; phase_mask = 4'b0001; go = 1'b1;
      @(posedge clock); #1; go = 1'b0;
      c = 0;
      while (own < 0 && c < 50) begin
         @(posedge clock);
         c++;
      end
      n_total++;
      if (c >= 50) $display("FAIL midreset_reach_wait got no ownership in %0d cycles required ownership", c);
      else n_pass++;
      repeat (3) @(posedge clock);
      #1; nrst = 1'b0;
      @(posedge clock); #1; nrst = 1'b1;
      repeat (8) @(posedge clock);
      #1;
      n_total++;
      if (busy !== 1'b0) $display("FAIL midreset_busy got %b required 0", busy);
      else n_pass++;
      n_total++;
      if (done_cnt !== 0) $display("FAIL midreset_done got %0d pulses required 0", done_cnt);
      else n_pass++;
      n_total++;
      if ({phases_done, timeout_err, cur_phase} !== 7'd0)
         $display("FAIL midreset_status got pd=%b to=%b cur=%0d required 0", phases_done, timeout_err, cur_phase);
      else n_pass++;
      n_total++;
      if (en_q.size() !== 1) $display("FAIL midreset_rearm got %0d ph_en pulses required 1", en_q.size());
      else n_pass++;
      hang[0] = 0;
   endtask

   initial begin
      for (int p = 0; p < 4; p++) begin
         delay[p] = 1; hang[p] = 0; cnt[p] = 0;
         addr_v[p] = '0; we_v[p] = 1'b0; dat_v[p] = '0;
      end
      test_reset();
      test_mask_1011();
      test_empty_mask();
      test_timeout();
      test_mem_isolation();
      test_back_to_back();
      test_random();
      test_reset_mid_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Top-level controller that runs up to four memory-sharing processing sub-blocks in fixed order (phase 0..3) over one shared single-port RAM.
- Each sub-block uses the en/start/done handshake and drives an 11-bit address, wr_en and 16-bit data_out.
- The sequencer arms and starts each enabled phase, waits for its done, and routes only the active phase's memory bus to the RAM.
- It provides a run-level done pulse and a watchdog timeout.

Parameters:
- WORD_WIDTH, 16, RAM data width.
- ADDR_WIDTH, 11, RAM address width.
- TIMEOUT, 4095, maximum WAIT cycles per phase before abort; 1..65535.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- nrst  in  1  reset, synchronous, active-low.
- go  in  1  run request; sampled only in IDLE.
- phase_mask  in  4  bit p=1 runs phase p; latched on go acceptance.
- ph_done  in  4  per-phase done level from sub-blocks.
- ph_address  in  4*ADDR_WIDTH  packed sub-block addresses; phase p at [p*11+:11].
- ph_wr_en  in  4  per-phase write enables.
- ph_data_out  in  4*WORD_WIDTH  packed sub-block write data; phase p at [p*16+:16].
- ph_en  out  4  one-cycle arm pulse to phase p (resets the sub-block to its wait-for-start state).
- ph_start  out  4  one-cycle start pulse to phase p.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_wr_en  out  1  RAM write enable.
- mem_data_out  out  WORD_WIDTH  RAM write data.
- busy  out  1  high from the cycle after go acceptance until FINISH completes.
- done  out  1  one-cycle pulse at end of run.
- cur_phase  out  2  index of the owning or last-selected phase.
- phases_done  out  4  bitmask of phases completed in the current/last run.
- timeout_err  out  1  sticky; set on watchdog abort, cleared on next go acceptance.

Behaviour:
- Reset (nrst=0 at posedge):
  - state=IDLE.
  - All registered outputs 0: ph_en, ph_start, busy, done, cur_phase, phases_done, timeout_err, owner_valid, wdog=0, idx=0.
  - Reset mid-run aborts immediately; no done pulse.
- States:
  - IDLE: if go: latch phase_mask, idx=0, phases_done=0, timeout_err=0, busy=1, go to SELECT. go while busy is ignored, and is not queued.
  - SELECT: find the lowest p>=idx with mask[p]=1. If found: cur_phase=p, go to ARM. Otherwise go to FINISH.
  - ARM: ph_en[cur_phase]=1 for exactly one cycle, then go to START. done from the previous run is stale and is not sampled here.
  - START: ph_start[cur_phase]=1 for one cycle, owner_valid=1, wdog=0, then go to WAIT.
  - WAIT: wdog increments each cycle.
    - If ph_done[cur_phase]=1: phases_done[cur_phase]=1, owner_valid=0, go to NEXT.
    - Else if wdog==TIMEOUT-1: timeout_err=1, owner_valid=0, go to FINISH. Remaining phases are skipped.
    - ph_done sampling takes priority over timeout in the same cycle.
  - NEXT: if cur_phase==3 go to FINISH; else idx=cur_phase+1, go to SELECT.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE. go in the FINISH cycle is ignored.
- Memory mux:
  - Combinational from registered owner_valid/cur_phase.
  - owner_valid=1: mem_address/mem_wr_en/mem_data_out = ph_* slice of cur_phase.
  - owner_valid=0: mem_wr_en=0, mem_address=0, mem_data_out=0.
  - ph_wr_en of non-owning phases never reaches the RAM.
- ph_done bits of non-current phases are ignored at all times.
- Timing:
  - Cycle count per enabled phase = 3 (SELECT, ARM, START) + WAIT cycles + 1 (NEXT).
  - mask=0 run: go accepted at edge N, done high in cycle N+2, busy high for 2 cycles.
- ph_en and ph_start are mutually exclusive and at most one bit of each is set per cycle.

Test Plan:
- Reset with go=1 and ph_done=4'hF -> all outputs 0, state IDLE; no ph_en pulse for 2 cycles after release with go=0.
- phase_mask=4'b1011, each model raises done 5 cycles after start -> ph_en/ph_start pulses in order 0,1,3 (phase 2 never pulsed); phases_done=4'b1011; done pulses once; timeout_err=0.
- phase_mask=4'b0000, go -> done pulse exactly 2 cycles after acceptance; no ph_en/ph_start; mem_wr_en stays 0.
- Phase 1 model never asserts done, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles; phases 2 and 3 are not started; phases_done=4'b0001; done pulse.
- Phase 0 owner writes addr 11'h248 data 16'h00AB while phase 2 holds wr_en=1 addr 11'h1C8 -> RAM sees only 11'h248/16'h00AB; mem_wr_en=0 outside WAIT.
- Stale done (ph_done[0]=1 left from a prior run) plus a second go -> phase 0 is re-armed and completion is taken only after a new done; go pulsed during the run is ignored; nrst pulsed mid-WAIT -> busy=0, no done pulse.
